regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with single-load scoreboard (optional forwarding: REGFILE_BYPASS_EN)
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd1_busy,
    output logic              rd2_busy,
    output logic              stall,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_issue_ready,
    input  logic              ld_ret_valid,
    input  logic [DATA_W-1:0] ld_ret_data,
    output logic              ld_ret_ready
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              tag_valid_q, tag_valid_d;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic wb_we;
    logic ret_fire;
    logic ret_accept;
    logic ld_we;

    // Effective write enables: x0 writes vanish, and the ALU write wins a same-index collision
    always_comb begin
        wb_we      = wb_en && !(ZERO_EN && (wb_addr == '0));
        ret_fire   = (state_q == S_WAIT) && ld_ret_valid;
        ret_accept = ret_fire && tag_valid_q;
        ld_we      = ret_accept && !(wb_we && (wb_addr == tag_q));
    end

    // Register array storage; reset clears every entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (ld_we) begin
                regs_q[tag_q] <= ld_ret_data;
            end
            if (wb_we) begin
                regs_q[wb_addr] <= wb_data;
            end
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
        end
    end

    // Next-state: tag a load in IDLE, retire it in WAIT, drop the tag on a younger ALU write
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        case (state_q)
            S_IDLE: begin
                if (ld_issue) begin
                    state_d     = S_WAIT;
                    tag_d       = ld_addr;
                    // A load to x0 still occupies the slot but never marks anything busy
                    tag_valid_d = !(ZERO_EN && (ld_addr == '0));
                end
            end
            S_WAIT: begin
                if (ld_ret_valid) begin
                    state_d     = S_IDLE;
                    tag_valid_d = 1'b0;
                end else if (wb_we && (wb_addr == tag_q)) begin
                    tag_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                tag_valid_d = 1'b0;
            end
        endcase
    end

    // FSM outputs: handshake readies and per-port busy flags
    always_comb begin
        ld_issue_ready = (state_q == S_IDLE);
        ld_ret_ready   = (state_q == S_WAIT);
        rd1_busy       = (state_q == S_WAIT) && tag_valid_q && (rs1_addr == tag_q)
                         && !(ZERO_EN && (rs1_addr == '0));
        rd2_busy       = (state_q == S_WAIT) && tag_valid_q && (rs2_addr == tag_q)
                         && !(ZERO_EN && (rs2_addr == '0));
`ifdef REGFILE_BYPASS_EN
        // The returning data is forwarded this cycle, so nothing needs to wait
        if (ret_accept) begin
            rd1_busy = 1'b0;
            rd2_busy = 1'b0;
        end
`endif
        stall = rd1_busy || rd2_busy;
    end

    // Combinational read ports
    always_comb begin
        rd1_data = regs_q[rs1_addr];
        rd2_data = regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (ld_we && (tag_q == rs1_addr)) rd1_data = ld_ret_data;
        if (ld_we && (tag_q == rs2_addr)) rd2_data = ld_ret_data;
        if (wb_we && (wb_addr == rs1_addr)) rd1_data = wb_data;
        if (wb_we && (wb_addr == rs2_addr)) rd2_data = wb_data;
`endif
        if (ZERO_EN && (rs1_addr == '0)) rd1_data = '0;
        if (ZERO_EN && (rs2_addr == '0)) rd2_data = '0;
    end

endmodule
